// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch controller states: issuing, parked on a stalled response, flushing a wrong-path request.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 - what decode sees when no real instruction is present.
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // Instructions are word aligned; low address bits are simply dropped.
  function automatic logic [31:0] word_align(input logic [31:0] i_addr);
    return {i_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_adder.sv
// fetch_unit_pc_adder: sequential-PC incrementer (address + 4, 32-bit wraparound).
// Latency: combinational.
// Backpressure: none.
module fetch_unit_pc_adder
  import fetch_pkg::*;
(
  input  logic [31:0] i_addr,
  output logic [31:0] o_sum
);

  // Modulo-2^32 add, so 32'hFFFF_FFFC rolls over to 32'h0000_0000.
  assign o_sum = i_addr + INSTR_BYTES;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - owns the PC, keeps one req/ack fetch outstanding, drives the IF/ID register.
// Latency: a word lands in IF/ID on the edge that samples imem_ack; a parked word one edge after stall drops.
// Backpressure: stall freezes PC and IF/ID; a response arriving under stall is parked and imem_req drops until drained.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrCode_IF,
  output logic [31:0] PCOutData_IF,
  output logic [31:0] PC_4_AdderResult_IF,
  output logic        valid_IF
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  // r_pc is the architectural next PC; r_req_addr is the address currently (or next) on the bus.
  // Keeping them apart means a redirect can never disturb a request that is still owed a response.
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_addr;
  logic [31:0] w_req_addr_nxt;

  // One-entry hold buffer for a response that arrived while decode was stalled.
  logic [31:0] r_hold_instr;
  logic [31:0] w_hold_instr_nxt;
  logic [31:0] r_hold_pc;
  logic [31:0] w_hold_pc_nxt;

  ifid_t       r_ifid;
  ifid_t       w_ifid_nxt;

  logic        w_eff_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_req_addr_p4;

  logic        w_load;
  logic [31:0] w_load_instr;
  logic [31:0] w_load_pc;
  logic [31:0] w_load_pc4;

  // Decode re-resolves its branch once the hazard clears, so a redirect under stall is dropped.
  assign w_eff_redirect = redirect & ~stall;
  assign w_redirect_pc  = word_align(redirect_pc);

  fetch_unit_pc_adder u_pc_adder (
    .i_addr (r_req_addr),
    .o_sum  (w_req_addr_p4)
  );

  // Request is held in FETCH and DROP; gated by reset so nothing is presented while in reset.
  assign imem_req  = ~reset & (r_state != S_HOLD);
  assign imem_addr = r_req_addr;

  assign instrCode_IF        = r_ifid.instr;
  assign PCOutData_IF        = r_ifid.pc;
  assign PC_4_AdderResult_IF = r_ifid.pc4;
  assign valid_IF            = r_ifid.valid;

  // Next-state, PC/address steering and choice of what (if anything) to hand to decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_load           = 1'b0;
    w_load_instr     = imem_rdata;
    w_load_pc        = r_req_addr;
    w_load_pc4       = w_req_addr_p4;

    case (r_state)
      S_FETCH: begin
        if (w_eff_redirect) begin
          w_pc_nxt = w_redirect_pc;
          if (imem_ack) begin
            // Wrong-path word: throw it away and start on the new target immediately.
            w_req_addr_nxt = w_redirect_pc;
          end else begin
            // The old request must still complete on the bus before the target can be issued.
            w_state_nxt = S_DROP;
          end
        end else if (imem_ack) begin
          w_pc_nxt = w_req_addr_p4;
          if (!stall) begin
            w_load         = 1'b1;
            w_req_addr_nxt = w_req_addr_p4;
          end else begin
            w_hold_instr_nxt = imem_rdata;
            w_hold_pc_nxt    = r_req_addr;
            w_state_nxt      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (w_eff_redirect) begin
          w_pc_nxt       = w_redirect_pc;
          w_req_addr_nxt = w_redirect_pc;
          w_state_nxt    = S_FETCH;
        end else if (!stall) begin
          // r_pc already holds hold_pc+4 here: it is only ever rewritten by a redirect, which empties the buffer.
          w_load         = 1'b1;
          w_load_instr   = r_hold_instr;
          w_load_pc      = r_hold_pc;
          w_load_pc4     = r_pc;
          w_req_addr_nxt = r_pc;
          w_state_nxt    = S_FETCH;
        end
      end

      S_DROP: begin
        if (w_eff_redirect) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (imem_ack) begin
          w_req_addr_nxt = w_eff_redirect ? w_redirect_pc : r_pc;
          w_state_nxt    = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // IF/ID: frozen under stall, otherwise a real word or a bubble that keeps the old PC fields.
    w_ifid_nxt = r_ifid;
    if (!stall) begin
      if (w_load) begin
        w_ifid_nxt.instr = w_load_instr;
        w_ifid_nxt.pc    = w_load_pc;
        w_ifid_nxt.pc4   = w_load_pc4;
        w_ifid_nxt.valid = 1'b1;
      end else begin
        w_ifid_nxt.instr = BUBBLE_INSTR;
        w_ifid_nxt.valid = 1'b0;
      end
    end
  end

  // Controller, PC, request address and hold buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_hold_instr <= BUBBLE_INSTR;
      r_hold_pc    <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid.instr <= BUBBLE_INSTR;
      r_ifid.pc    <= 32'h0000_0000;
      r_ifid.pc4   <= 32'h0000_0000;
      r_ifid.valid <= 1'b0;
    end else begin
      r_ifid <= w_ifid_nxt;
    end
  end

endmodule
